pe_array_feeder: RTL and testbench

//  Upstream operand feeder for the NxN systolic PE array of the matrix multiplier.

---
 rtl/mm_pkg.sv | 28 ++
 rtl/feeder_bank.sv | 55 +++++
 rtl/pe_array_feeder.sv | 144 ++++++++++++++
 tb/tb_pe_array_feeder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared defaults, data type codes and feeder FSM states for the matrix multiplier
package mm_pkg;

  localparam int N_DEF  = 4;
  localparam int DW_DEF = 32;

  // operand data type codes; this feeder carries the int32 path
  localparam logic [2:0] DT_FP32  = 3'b000;
  localparam logic [2:0] DT_FP16  = 3'b001;
  localparam logic [2:0] DT_BF16  = 3'b010;
  localparam logic [2:0] DT_INT8  = 3'b011;
  localparam logic [2:0] DT_INT16 = 3'b100;
  localparam logic [2:0] DT_INT32 = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  // element index a lane reads on a given wavefront step (may fall outside 0..N-1)
  function automatic int diag_index(input int step, input int lane);
    return step - lane;
  endfunction

endpackage

// File: rtl/feeder_bank.sv
// rtl/feeder_bank.sv - NxN operand register bank with one write port and N skewed diagonal read lanes
module feeder_bank
  import mm_pkg::*;
#(
  parameter int  N        = N_DEF,
  parameter int  DW       = DW_DEF,
  parameter bit  ROW_DIAG = 1'b1,
  localparam int IW       = (N > 1) ? $clog2(N) : 1,
  localparam int SW       = $clog2(2 * N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_wr_en,
  input  logic [IW-1:0]   i_wr_row,
  input  logic [IW-1:0]   i_wr_col,
  input  logic [DW-1:0]   i_wr_data,
  input  logic [SW-1:0]   i_step,
  output logic [N*DW-1:0] o_lanes
);

  localparam logic [IW:0] LP_N = (IW + 1)'(N);

  logic [DW-1:0] r_mem [N][N];
  logic          w_in_range;

  // indices beyond N-1 (only reachable when N is not a power of two) drop the write
  assign w_in_range = ({1'b0, i_wr_row} < LP_N) && ({1'b0, i_wr_col} < LP_N);

  // element storage: cleared on reset, single write port
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_mem[r][c] <= '0;
        end
      end
    end else if (i_wr_en && w_in_range) begin
      r_mem[i_wr_row][i_wr_col] <= i_wr_data;
    end
  end

  // lane l reads element (l, step-l) for row banks or (step-l, l) for column banks, else 0
  always_comb begin
    o_lanes = '0;
    for (int l = 0; l < N; l++) begin
      int k;
      k = diag_index(int'(i_step), l);
      if (k >= 0 && k < N) begin
        if (ROW_DIAG) o_lanes[l*DW +: DW] = r_mem[l][k[IW-1:0]];
        else          o_lanes[l*DW +: DW] = r_mem[k[IW-1:0]][l];
      end
    end
  end

endmodule

// File: rtl/pe_array_feeder.sv
// rtl/pe_array_feeder.sv - skewed wavefront operand feeder for the NxN systolic PE array
module pe_array_feeder
  import mm_pkg::*;
#(
  parameter int  N  = N_DEF,
  parameter int  DW = DW_DEF,
  localparam int IW = (N > 1) ? $clog2(N) : 1,
  localparam int SW = $clog2(2 * N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_wr_en,
  input  logic            i_wr_sel,
  input  logic [IW-1:0]   i_wr_row,
  input  logic [IW-1:0]   i_wr_col,
  input  logic [DW-1:0]   i_wr_data,
  input  logic            i_start,
  input  logic            i_step_done,
  output logic [N*DW-1:0] o_row_data,
  output logic [N*DW-1:0] o_col_data,
  output logic            o_edge_load,
  output logic            o_array_clr,
  output logic            o_busy,
  output logic            o_done
);

  localparam logic [SW-1:0] LP_LAST_STEP = SW'(2 * N - 2);

  state_t          r_state;
  logic [SW-1:0]   r_step;
  logic [N*DW-1:0] r_row_data;
  logic [N*DW-1:0] r_col_data;
  logic            r_edge_load;
  logic            r_array_clr;
  logic            r_busy;
  logic            r_done;

  logic            w_idle;
  logic            w_wr_a;
  logic            w_wr_b;
  logic            w_last;
  logic [SW-1:0]   w_rd_step;
  logic [N*DW-1:0] w_row_lanes;
  logic [N*DW-1:0] w_col_lanes;

  // banks only accept writes while idle, so a running job sees a stable matrix
  assign w_idle = (r_state == ST_IDLE);
  assign w_wr_a = i_wr_en && !i_wr_sel && w_idle;
  assign w_wr_b = i_wr_en &&  i_wr_sel && w_idle;
  assign w_last = (r_step == LP_LAST_STEP);

  // banks are read with the step the upcoming ISSUE cycle will present
  assign w_rd_step = (r_state == ST_WAIT) ? r_step + SW'(1) : r_step;

  feeder_bank #(.N(N), .DW(DW), .ROW_DIAG(1'b1)) u_bank_a (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_a),
    .i_wr_row  (i_wr_row),
    .i_wr_col  (i_wr_col),
    .i_wr_data (i_wr_data),
    .i_step    (w_rd_step),
    .o_lanes   (w_row_lanes)
  );

  feeder_bank #(.N(N), .DW(DW), .ROW_DIAG(1'b0)) u_bank_b (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_b),
    .i_wr_row  (i_wr_row),
    .i_wr_col  (i_wr_col),
    .i_wr_data (i_wr_data),
    .i_step    (w_rd_step),
    .o_lanes   (w_col_lanes)
  );

  // job sequencer: clear, then one ISSUE/WAIT pair per wavefront, then a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_step      <= '0;
      r_row_data  <= '0;
      r_col_data  <= '0;
      r_edge_load <= 1'b0;
      r_array_clr <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_edge_load <= 1'b0;
      r_array_clr <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state     <= ST_CLR;
            r_step      <= '0;
            r_busy      <= 1'b1;
            r_array_clr <= 1'b1;
          end
        end
        ST_CLR: begin
          r_state     <= ST_ISSUE;
          r_edge_load <= 1'b1;
          r_row_data  <= w_row_lanes;
          r_col_data  <= w_col_lanes;
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_step_done) begin
            if (w_last) begin
              r_state    <= ST_FIN;
              r_done     <= 1'b1;
              r_row_data <= '0;
              r_col_data <= '0;
            end else begin
              r_state     <= ST_ISSUE;
              r_step      <= r_step + SW'(1);
              r_edge_load <= 1'b1;
              r_row_data  <= w_row_lanes;
              r_col_data  <= w_col_lanes;
            end
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_row_data  = r_row_data;
  assign o_col_data  = r_col_data;
  assign o_edge_load = r_edge_load;
  assign o_array_clr = r_array_clr;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_pe_array_feeder.sv
// tb/tb_pe_array_feeder.sv - self-checking bench for pe_array_feeder against a matrix-level model
module tb_pe_array_feeder;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_wr_en = 1'b0;
  logic            i_wr_sel = 1'b0;
  logic [IW-1:0]   i_wr_row = '0;
  logic [IW-1:0]   i_wr_col = '0;
  logic [DW-1:0]   i_wr_data = '0;
  logic            i_start = 1'b0;
  logic            i_step_done = 1'b0;
  logic [N*DW-1:0] o_row_data;
  logic [N*DW-1:0] o_col_data;
  logic            o_edge_load;
  logic            o_array_clr;
  logic            o_busy;
  logic            o_done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ma [N][N];
  logic [DW-1:0] mb [N][N];

  pe_array_feeder #(.N(N), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_wr_en     (i_wr_en),
    .i_wr_sel    (i_wr_sel),
    .i_wr_row    (i_wr_row),
    .i_wr_col    (i_wr_col),
    .i_wr_data   (i_wr_data),
    .i_start     (i_start),
    .i_step_done (i_step_done),
    .o_row_data  (o_row_data),
    .o_col_data  (o_col_data),
    .o_edge_load (o_edge_load),
    .o_array_clr (o_array_clr),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  // wavefront s: row edge i sees A[i][s-i], column edge j sees B[s-j][j], else 0
  function automatic logic [N*DW-1:0] exp_lanes(input bit is_a, input int s);
    logic [N*DW-1:0] v;
    v = '0;
    for (int l = 0; l < N; l++) begin
      if (s - l >= 0 && s - l < N) v[l*DW +: DW] = is_a ? ma[l][s-l] : mb[s-l][l];
    end
    return v;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = '0;
        mb[r][c] = '0;
      end
  endtask

  task automatic write_elem(input bit sel, input int r, input int c, input logic [DW-1:0] d);
    @(negedge clk);
    i_wr_en = 1'b1; i_wr_sel = sel; i_wr_row = IW'(r); i_wr_col = IW'(c); i_wr_data = d;
    if (sel) mb[r][c] = d; else ma[r][c] = d;
    @(negedge clk);
    i_wr_en = 1'b0;
  endtask

  task automatic load_matrices(input bit random_fill);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        write_elem(1'b0, r, c, random_fill ? $urandom() : DW'(r * N + c + 1));
        write_elem(1'b1, r, c, random_fill ? $urandom() : ((r == c) ? DW'(1) : DW'(0)));
      end
  endtask

  // runs one job; step_done comes d cycles after each edge_load (or is held high when cont)
  task automatic run_job(input string name, input int d, input bit cont, input bit glitch,
                         input bit poke, input bit co_write);
    int loads, t_last, done_at, idle_at, done_cnt;
    loads = 0; t_last = 0; done_at = -1; idle_at = -1; done_cnt = 0;
    @(negedge clk);
    i_start = 1'b1;
    i_step_done = cont;
    if (co_write) begin
      i_wr_en = 1'b1; i_wr_sel = 1'b0; i_wr_row = 2'd3; i_wr_col = 2'd3; i_wr_data = 32'h7FFF_FFFF;
      ma[3][3] = 32'h7FFF_FFFF;
    end
    for (int t = 1; t <= 400 && idle_at < 0; t++) begin
      @(negedge clk);
      i_start = 1'b0;
      i_wr_en = 1'b0;
      if (!cont) i_step_done = 1'b0;
      checks++;
      if (o_array_clr !== (t == 1)) begin
        errors++;
        $display("FAIL %s array_clr t=%0d: got %b expected %b", name, t, o_array_clr, (t == 1));
      end
      if (t == 1) begin
        checks++;
        if (o_row_data !== '0 || o_col_data !== '0 || o_busy !== 1'b1) begin
          errors++;
          $display("FAIL %s clr_cycle: got row=%h col=%h busy=%b expected zero lanes, busy=1",
                   name, o_row_data, o_col_data, o_busy);
        end
      end
      if (o_edge_load === 1'b1) begin
        checks++;
        if (t != 2 + loads * (d + 1)) begin
          errors++;
          $display("FAIL %s load_time step=%0d: got t=%0d expected t=%0d", name, loads, t, 2 + loads * (d + 1));
        end
        checks++;
        if (o_row_data !== exp_lanes(1'b1, loads) || o_col_data !== exp_lanes(1'b0, loads)) begin
          errors++;
          $display("FAIL %s lanes step=%0d: got row=%h col=%h expected row=%h col=%h", name, loads,
                   o_row_data, o_col_data, exp_lanes(1'b1, loads), exp_lanes(1'b0, loads));
        end
        loads++;
        t_last = t;
        if (glitch && loads == 1) i_step_done = 1'b1;
      end
      if (o_done === 1'b1) begin
        done_at = t;
        done_cnt++;
      end
      if (o_busy !== 1'b1) idle_at = t;
      if (!cont && loads > 0 && t == t_last + d) i_step_done = 1'b1;
      if (poke && t == 4) begin
        i_wr_en = 1'b1; i_wr_sel = 1'b0; i_wr_row = 2'd0; i_wr_col = 2'd0; i_wr_data = 32'd99;
        i_start = 1'b1;
      end
    end
    i_step_done = 1'b0;
    i_start = 1'b0;
    i_wr_en = 1'b0;
    checks++;
    if (idle_at < 0) begin
      errors++;
      $display("FAIL %s timeout: got busy still high expected job end within 400 cycles", name);
    end
    checks++;
    if (loads != 2 * N - 1) begin
      errors++;
      $display("FAIL %s load_count: got %0d expected %0d", name, loads, 2 * N - 1);
    end
    checks++;
    if (done_cnt != 1 || done_at != 2 + (2 * N - 1) * (d + 1)) begin
      errors++;
      $display("FAIL %s done: got %0d pulses, last t=%0d expected 1 pulse at t=%0d", name, done_cnt,
               done_at, 2 + (2 * N - 1) * (d + 1));
    end
    checks++;
    if (idle_at != 2 + (2 * N - 1) * (d + 1) + 1) begin
      errors++;
      $display("FAIL %s busy_end: got t=%0d expected t=%0d", name, idle_at, 2 + (2 * N - 1) * (d + 1) + 1);
    end
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if (o_row_data !== '0 || o_col_data !== '0 || o_edge_load !== 1'b0 || o_array_clr !== 1'b0 ||
        o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL %s: got row=%h col=%h load=%b clr=%b busy=%b done=%b expected all 0", name,
               o_row_data, o_col_data, o_edge_load, o_array_clr, o_busy, o_done);
    end
  endtask

  task automatic test_reset();
    bit seen;
    model_clear();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet("reset_initial");
    rst = 1'b0;
    write_elem(1'b0, 1, 1, 32'd5);
    write_elem(1'b1, 2, 0, 32'd6);
    @(negedge clk);
    i_start = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_edge_load === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_reach_wait: got no edge_load expected one within 10 cycles");
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_quiet("reset_mid_wait");
    end
    rst = 1'b0;
    model_clear();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_quiet("reset_after_release");
    end
    run_job("reset_banks_zero", 2, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_identity();
    load_matrices(1'b0);
    run_job("identity", 5, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_job("step_done_held", 1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_busy_ignored();
    run_job("busy_poke", 3, 1'b0, 1'b0, 1'b1, 1'b0);
    run_job("busy_rerun", 2, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_write();
    load_matrices(1'b1);
    run_job("start_with_write", 2, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_issue_glitch();
    run_job("issue_glitch", 5, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) begin
      load_matrices(1'b1);
      run_job("random", int'($urandom_range(4, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_back_to_back();
    test_busy_ignored();
    test_start_write();
    test_issue_glitch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
